// File: rtl/tx_uart_logic.sv
// UART transmit packet framer: sends cmd, len, len data bytes from the packet buffer, then ~checksum.
// Optional per-byte tx_done timeout abort is built when TXUART_TIMEOUT_EN is defined.
module tx_uart_logic #(
  parameter int NUMBER  = 256,
  parameter int TIMEOUT = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                cmd_tx,
  input  logic [7:0]                len_tx,
  output logic [$clog2(NUMBER)-1:0] rd_addr,
  input  logic [7:0]                rd_data,
  output logic [7:0]                tx_data,
  output logic                      tx_send,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      pck_sent,
  output logic                      tx_err
);
  localparam int AW = $clog2(NUMBER);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [9:0]  idx_q, idx_d;
  logic        pck_sent_q, pck_sent_d;

  logic [8:0]  len_buf;
  logic [9:0]  last_idx;
  logic        is_last;
  logic        is_data;
  logic [7:0]  byte_sel;

  // A zero length field encodes a full 256-byte payload.
  assign len_buf  = {len_q == 8'd0, len_q};
  assign last_idx = {1'b0, len_buf} + 10'd2;
  assign is_last  = (idx_q == last_idx);
  assign is_data  = (idx_q >= 10'd2) && (idx_q < last_idx);

  assign rd_addr  = is_data ? AW'(idx_q - 10'd2) : '0;
  assign busy     = (state_q != S_IDLE);
  assign tx_send  = (state_q == S_SEND);
  assign tx_data  = tx_data_q;
  assign pck_sent = pck_sent_q;

  always_comb begin
    byte_sel = rd_data;
    if (idx_q == 10'd0)      byte_sel = cmd_q;
    else if (idx_q == 10'd1) byte_sel = len_q;
    else if (is_last)        byte_sel = ~sum_q;
  end

`ifdef TXUART_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tx_err_q, tx_err_d;
  assign tx_err = tx_err_q;
`else
  assign tx_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no branch can infer a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    pck_sent_d = 1'b0;
`ifdef TXUART_TIMEOUT_EN
    cnt_d      = cnt_q;
    tx_err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d   = cmd_tx;
          len_d   = len_tx;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tx_data_d = byte_sel;
        if (!is_last) sum_d = sum_q + byte_sel;
        state_d   = S_SEND;
      end
      S_SEND: begin
`ifdef TXUART_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (is_last) begin
            pck_sent_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = S_FETCH;
          end
        end
`ifdef TXUART_TIMEOUT_EN
        // Abort fires so that tx_err lands exactly TIMEOUT cycles after tx_send.
        else if (cnt_q == TW'(TIMEOUT - 2)) begin
          tx_err_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      pck_sent_q <= 1'b0;
`ifdef TXUART_TIMEOUT_EN
      cnt_q      <= '0;
      tx_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      pck_sent_q <= pck_sent_d;
`ifdef TXUART_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tx_err_q   <= tx_err_d;
`endif
    end
  end

endmodule
